// File: rtl/match_best_select_if.sv
// Signal bundle between match_best_select and the query buffer, descriptor RAM,
// distance unit and match-pair output path.
interface match_best_select_if #(
    parameter int IDX_W = 10
);
    logic             i_start;
    logic [255:0]     i_query;
    logic [IDX_W-1:0] i_count;
    logic             o_busy;
    logic             o_rd_en;
    logic [IDX_W-1:0] o_rd_addr;
    logic [255:0]     i_rd_data;
    logic             o_dist_ready;
    logic [255:0]     o_dist_value_0;
    logic [255:0]     o_dist_value_1;
    logic             i_dist_ready;
    logic [15:0]      i_dist_value;
    logic             o_done;
    logic             o_found;
    logic [IDX_W-1:0] o_best_idx;
    logic [15:0]      o_best_dist;
    logic [15:0]      o_second_dist;

    modport slave (
        input  i_start, i_query, i_count, i_rd_data, i_dist_ready, i_dist_value,
        output o_busy, o_rd_en, o_rd_addr, o_dist_ready, o_dist_value_0, o_dist_value_1,
        output o_done, o_found, o_best_idx, o_best_dist, o_second_dist
    );

    modport master (
        output i_start, i_query, i_count, i_rd_data, i_dist_ready, i_dist_value,
        input  o_busy, o_rd_en, o_rd_addr, o_dist_ready, o_dist_value_0, o_dist_value_1,
        input  o_done, o_found, o_best_idx, o_best_dist, o_second_dist
    );
endinterface

// File: rtl/match_best_select.sv
// Streams every candidate descriptor past one query, keeps the best and second-best
// Hamming distances and reports the best index qualified by a ratio test.
module match_best_select #(
    parameter int IDX_W     = 10,
    parameter int RATIO_NUM = 3,
    parameter int RATIO_DEN = 4
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    match_best_select_if.slave bus
);
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam logic [15:0]      DIST_NONE = 16'hFFFF;
    localparam logic [IDX_W-1:0] IDX_ZERO  = {IDX_W{1'b0}};
    localparam logic [IDX_W-1:0] IDX_ONE   = {{(IDX_W-1){1'b0}}, 1'b1};

    // Products are kept at full 20-bit width so no distance can overflow the comparison.
    function automatic logic ratio_unique(input logic [15:0] best, input logic [15:0] second);
        logic [19:0] lhs;
        logic [19:0] rhs;
        lhs = 20'(best) * 20'(RATIO_DEN);
        rhs = 20'(second) * 20'(RATIO_NUM);
        return (best != DIST_NONE) && ((second == DIST_NONE) || (lhs < rhs));
    endfunction

    state_t           state_r;
    logic [255:0]     query_r;
    logic [IDX_W-1:0] count_r;
    logic [IDX_W-1:0] issue_cnt_r;
    logic [IDX_W-1:0] rcv_cnt_r;
    logic [IDX_W-1:0] sent_cnt_r;
    logic [15:0]      best_r;
    logic [15:0]      second_r;
    logic [IDX_W-1:0] best_idx_r;
    logic             busy_r;
    logic             rd_en_r;
    logic [IDX_W-1:0] rd_addr_r;
    logic             dist_ready_r;
    logic             done_r;
    logic             found_r;
    logic [IDX_W-1:0] best_idx_out_r;
    logic [15:0]      best_dist_out_r;
    logic [15:0]      second_dist_out_r;

    logic             collect_s;
    logic [IDX_W:0]   avail_s;
    logic             accept_s;
    logic [15:0]      best_nxt_s;
    logic [15:0]      second_nxt_s;
    logic [IDX_W-1:0] best_idx_nxt_s;

    // A result is only taken while a pair is outstanding, including one issued this cycle.
    assign collect_s = (state_r == ST_ISSUE) || (state_r == ST_DRAIN);
    assign avail_s   = {1'b0, sent_cnt_r} + {{IDX_W{1'b0}}, dist_ready_r};
    assign accept_s  = bus.i_dist_ready && collect_s && ({1'b0, rcv_cnt_r} < avail_s);

    // Best / second-best update; strict compares keep the lower index on ties.
    always_comb begin
        best_nxt_s     = best_r;
        second_nxt_s   = second_r;
        best_idx_nxt_s = best_idx_r;
        if (accept_s && (bus.i_dist_value != DIST_NONE)) begin
            if (bus.i_dist_value < best_r) begin
                second_nxt_s   = best_r;
                best_nxt_s     = bus.i_dist_value;
                best_idx_nxt_s = rcv_cnt_r;
            end else if (bus.i_dist_value < second_r) begin
                second_nxt_s = bus.i_dist_value;
            end else begin
                second_nxt_s = second_r;
            end
        end else begin
            best_nxt_s = best_r;
        end
    end

    // Control FSM, counters, search registers and all registered outputs.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_r           <= ST_IDLE;
            query_r           <= 256'd0;
            count_r           <= IDX_ZERO;
            issue_cnt_r       <= IDX_ZERO;
            rcv_cnt_r         <= IDX_ZERO;
            sent_cnt_r        <= IDX_ZERO;
            best_r            <= DIST_NONE;
            second_r          <= DIST_NONE;
            best_idx_r        <= IDX_ZERO;
            busy_r            <= 1'b0;
            rd_en_r           <= 1'b0;
            rd_addr_r         <= IDX_ZERO;
            dist_ready_r      <= 1'b0;
            done_r            <= 1'b0;
            found_r           <= 1'b0;
            best_idx_out_r    <= IDX_ZERO;
            best_dist_out_r   <= DIST_NONE;
            second_dist_out_r <= DIST_NONE;
        end else begin
            dist_ready_r <= rd_en_r;
            done_r       <= 1'b0;
            if (collect_s) begin
                best_r     <= best_nxt_s;
                second_r   <= second_nxt_s;
                best_idx_r <= best_idx_nxt_s;
                if (accept_s) begin
                    rcv_cnt_r <= rcv_cnt_r + IDX_ONE;
                end
                if (dist_ready_r) begin
                    sent_cnt_r <= sent_cnt_r + IDX_ONE;
                end
            end
            case (state_r)
                ST_IDLE: begin
                    rd_en_r <= 1'b0;
                    if (bus.i_start) begin
                        query_r     <= bus.i_query;
                        count_r     <= bus.i_count;
                        rcv_cnt_r   <= IDX_ZERO;
                        sent_cnt_r  <= IDX_ZERO;
                        best_r      <= DIST_NONE;
                        second_r    <= DIST_NONE;
                        best_idx_r  <= IDX_ZERO;
                        busy_r      <= 1'b1;
                        if (bus.i_count == IDX_ZERO) begin
                            // Empty candidate set reports straight away with cleared results.
                            state_r           <= ST_DONE;
                            done_r            <= 1'b1;
                            found_r           <= 1'b0;
                            best_idx_out_r    <= IDX_ZERO;
                            best_dist_out_r   <= DIST_NONE;
                            second_dist_out_r <= DIST_NONE;
                            issue_cnt_r       <= IDX_ZERO;
                        end else begin
                            state_r     <= ST_ISSUE;
                            rd_en_r     <= 1'b1;
                            rd_addr_r   <= IDX_ZERO;
                            issue_cnt_r <= IDX_ONE;
                        end
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_ISSUE: begin
                    if (issue_cnt_r == count_r) begin
                        rd_en_r <= 1'b0;
                        state_r <= ST_DRAIN;
                    end else begin
                        rd_en_r     <= 1'b1;
                        rd_addr_r   <= issue_cnt_r;
                        issue_cnt_r <= issue_cnt_r + IDX_ONE;
                    end
                end
                ST_DRAIN: begin
                    rd_en_r <= 1'b0;
                    if (rcv_cnt_r == count_r) begin
                        state_r           <= ST_DONE;
                        done_r            <= 1'b1;
                        found_r           <= ratio_unique(best_r, second_r);
                        best_idx_out_r    <= best_idx_r;
                        best_dist_out_r   <= best_r;
                        second_dist_out_r <= second_r;
                    end else begin
                        state_r <= ST_DRAIN;
                    end
                end
                ST_DONE: begin
                    rd_en_r <= 1'b0;
                    busy_r  <= 1'b0;
                    state_r <= ST_IDLE;
                end
                default: begin
                    rd_en_r <= 1'b0;
                    busy_r  <= 1'b0;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.o_busy         = busy_r;
    assign bus.o_rd_en        = rd_en_r;
    assign bus.o_rd_addr      = rd_addr_r;
    assign bus.o_dist_ready   = dist_ready_r;
    assign bus.o_dist_value_0 = query_r;
    assign bus.o_dist_value_1 = bus.i_rd_data;
    assign bus.o_done         = done_r;
    assign bus.o_found        = found_r;
    assign bus.o_best_idx     = best_idx_out_r;
    assign bus.o_best_dist    = best_dist_out_r;
    assign bus.o_second_dist  = second_dist_out_r;
endmodule

// File: tb/tb_match_best_select.sv
// Scoreboard bench for match_best_select with a descriptor RAM and a 3-cycle distance-unit model.
module tb_match_best_select;
    typedef struct {
        int          n;
        logic [9:0]  idx;
        logic [15:0] best;
        logic [15:0] second;
        logic        found;
        int          start_cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   done_cnt = 0;
    int   last_dr_cyc = 0;
    int   rd_cnt = 0;
    int   dr_idx = 0;
    bit   spur = 1'b0;
    logic [255:0] cur_query = 256'd0;
    logic [15:0]  dist_tab [0:15];
    exp_t sb [$];

    match_best_select_if #(.IDX_W(10)) bus ();

    match_best_select #(.IDX_W(10), .RATIO_NUM(3), .RATIO_DEN(4)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    initial begin
        forever begin
            @(posedge clk);
            cyc = cyc + 1;
        end
    end

    function automatic logic [255:0] ram_word(input int a);
        logic [31:0] w;
        w = (32'(a) * 32'h9E37_79B1) ^ 32'h5A5A_1234;
        return {w, ~w, w + 32'd1, w ^ 32'hFFFF_0000, w, ~w, w - 32'd7, 32'(a)};
    endfunction

    // RAM and distance-unit model: checks each pair handed to the distance unit.
    initial begin
        logic        rd_q;
        logic [9:0]  a_q;
        logic        dr_q;
        logic [15:0] d_q;
        logic        s0_v = 1'b0;
        logic        s1_v = 1'b0;
        logic [15:0] s0_d = 16'd0;
        logic [15:0] s1_d = 16'd0;
        forever begin
            @(negedge clk);
            #1;
            rd_q = bus.o_rd_en;
            a_q  = bus.o_rd_addr;
            if (bus.o_rd_en) begin
                checks++;
                if (bus.o_rd_addr !== 10'(rd_cnt)) begin
                    errors++;
                    $display("FAIL rd_addr got %0d want %0d", bus.o_rd_addr, rd_cnt);
                end
                rd_cnt++;
            end
            dr_q = bus.o_dist_ready;
            d_q  = 16'hFFFF;
            if (dr_q) begin
                checks++;
                if ((bus.o_dist_value_1 !== ram_word(dr_idx)) || (bus.o_dist_value_0 !== cur_query)) begin
                    errors++;
                    $display("FAIL dist_pair idx %0d got v0=%h v1=%h want v0=%h v1=%h", dr_idx,
                             bus.o_dist_value_0[31:0], bus.o_dist_value_1[31:0],
                             cur_query[31:0], ram_word(dr_idx) & 256'hFFFF_FFFF);
                end
                if (dr_idx < 16) d_q = dist_tab[dr_idx];
                dr_idx++;
            end
            @(posedge clk);
            #1;
            bus.i_rd_data    = rd_q ? ram_word(int'(a_q)) : 256'd0;
            bus.i_dist_ready = s1_v | spur;
            bus.i_dist_value = s1_v ? s1_d : 16'd1;
            spur = 1'b0;
            s1_v = s0_v;
            s1_d = s0_d;
            s0_v = dr_q;
            s0_d = d_q;
        end
    end

    // Result monitor: pops the scoreboard on every o_done.
    initial begin
        exp_t e;
        int   want_cyc;
        forever begin
            @(negedge clk);
            #1;
            if (bus.i_dist_ready) last_dr_cyc = cyc;
            if (bus.o_done) begin
                done_cnt++;
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_done got done=1 want none");
                end else begin
                    e = sb.pop_front();
                    checks += 6;
                    if (bus.o_best_idx !== e.idx) begin
                        errors++; $display("FAIL best_idx got %0d want %0d", bus.o_best_idx, e.idx);
                    end
                    if (bus.o_best_dist !== e.best) begin
                        errors++; $display("FAIL best_dist got %h want %h", bus.o_best_dist, e.best);
                    end
                    if (bus.o_second_dist !== e.second) begin
                        errors++; $display("FAIL second_dist got %h want %h", bus.o_second_dist, e.second);
                    end
                    if (bus.o_found !== e.found) begin
                        errors++; $display("FAIL found got %b want %b", bus.o_found, e.found);
                    end
                    if (bus.o_busy !== 1'b1 || rd_cnt != e.n) begin
                        errors++; $display("FAIL busy_reads got busy=%b reads=%0d want busy=1 reads=%0d",
                                           bus.o_busy, rd_cnt, e.n);
                    end
                    want_cyc = (e.n == 0) ? e.start_cyc : last_dr_cyc + 2;
                    if (cyc != want_cyc) begin
                        errors++; $display("FAIL done_cycle got %0d want %0d", cyc, want_cyc);
                    end
                end
            end
        end
    end

    task automatic start_run(input int n, input logic [255:0] q, input logic [9:0] eidx,
                             input logic [15:0] eb, input logic [15:0] es, input logic ef,
                             input bit push, input bit spur_in);
        exp_t e;
        rd_cnt = 0;
        dr_idx = 0;
        @(negedge clk);
        cur_query   = q;
        bus.i_query = q;
        bus.i_count = 10'(n);
        bus.i_start = 1'b1;
        spur        = spur_in;
        @(negedge clk);
        bus.i_start = 1'b0;
        if (push) begin
            e.n = n; e.idx = eidx; e.best = eb; e.second = es; e.found = ef; e.start_cyc = cyc;
            sb.push_back(e);
        end
    endtask

    task automatic wait_done(output bit timed_out);
        int d0;
        int k;
        d0 = done_cnt;
        k = 0;
        while (done_cnt == d0 && k < 200) begin
            @(negedge clk);
            #2;
            k++;
        end
        timed_out = (done_cnt == d0);
    endtask

    task automatic test_reset();
        @(negedge clk);
        #2;
        checks += 4;
        if ({bus.o_busy, bus.o_rd_en, bus.o_dist_ready, bus.o_done, bus.o_found} !== 5'b0) begin
            errors++; $display("FAIL reset_flags got %b want 00000",
                               {bus.o_busy, bus.o_rd_en, bus.o_dist_ready, bus.o_done, bus.o_found});
        end
        if (bus.o_best_idx !== 10'd0) begin
            errors++; $display("FAIL reset_idx got %0d want 0", bus.o_best_idx);
        end
        if ({bus.o_best_dist, bus.o_second_dist} !== 32'hFFFF_FFFF) begin
            errors++; $display("FAIL reset_dists got %h %h want ffff ffff", bus.o_best_dist, bus.o_second_dist);
        end
        if (bus.o_dist_value_0 !== 256'd0) begin
            errors++; $display("FAIL reset_query got %h want 0", bus.o_dist_value_0[31:0]);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_ratio_reject();
        bit to;
        dist_tab[0] = 16'd20; dist_tab[1] = 16'd10; dist_tab[2] = 16'd30; dist_tab[3] = 16'd12;
        start_run(4, {8{32'hC0FF_EE01}}, 10'd1, 16'd10, 16'd12, 1'b0, 1'b1, 1'b0);
        wait_done(to);
        checks++;
        if (to) begin errors++; $display("FAIL ratio_reject_timeout got no done want done"); end
        @(negedge clk);
        #2;
        checks++;
        if (bus.o_done !== 1'b0 || bus.o_best_dist !== 16'd10 || bus.o_busy !== 1'b0) begin
            errors++; $display("FAIL hold_after_done got done=%b best=%h busy=%b want done=0 best=000a busy=0",
                               bus.o_done, bus.o_best_dist, bus.o_busy);
        end
    endtask

    task automatic test_unique_with_reject();
        bit to;
        dist_tab[0] = 16'd30; dist_tab[1] = 16'd8; dist_tab[2] = 16'hFFFF;
        start_run(3, {8{32'h1234_ABCD}}, 10'd1, 16'd8, 16'd30, 1'b1, 1'b1, 1'b1);
        wait_done(to);
        checks++;
        if (to) begin errors++; $display("FAIL unique_timeout got no done want done"); end
    endtask

    task automatic test_all_rejected();
        bit to;
        dist_tab[0] = 16'hFFFF; dist_tab[1] = 16'hFFFF; dist_tab[2] = 16'hFFFF;
        start_run(3, {8{32'h0F0F_0F0F}}, 10'd0, 16'hFFFF, 16'hFFFF, 1'b0, 1'b1, 1'b0);
        wait_done(to);
        checks++;
        if (to) begin errors++; $display("FAIL all_rejected_timeout got no done want done"); end
    endtask

    task automatic test_back_to_back();
        bit to;
        dist_tab[0] = 16'd15; dist_tab[1] = 16'd15;
        start_run(2, {8{32'hDEAD_BEEF}}, 10'd0, 16'd15, 16'd15, 1'b0, 1'b1, 1'b0);
        wait_done(to);
        checks++;
        if (to) begin errors++; $display("FAIL tie_timeout got no done want done"); end
    endtask

    task automatic test_zero_count();
        bit to;
        start_run(0, {8{32'h7777_0000}}, 10'd0, 16'hFFFF, 16'hFFFF, 1'b0, 1'b1, 1'b0);
        wait_done(to);
        checks++;
        if (to) begin errors++; $display("FAIL zero_count_timeout got no done want done"); end
    endtask

    task automatic test_start_while_busy();
        bit to;
        int d0;
        dist_tab[0] = 16'd50; dist_tab[1] = 16'd40; dist_tab[2] = 16'd60; dist_tab[3] = 16'd7;
        dist_tab[4] = 16'd90; dist_tab[5] = 16'd30; dist_tab[6] = 16'd100; dist_tab[7] = 16'd45;
        d0 = done_cnt;
        start_run(8, {8{32'hA5A5_0101}}, 10'd3, 16'd7, 16'd30, 1'b1, 1'b1, 1'b0);
        repeat (2) @(negedge clk);
        bus.i_query = {8{32'h1111_2222}};
        bus.i_count = 10'd3;
        bus.i_start = 1'b1;
        @(negedge clk);
        bus.i_start = 1'b0;
        wait_done(to);
        repeat (20) @(negedge clk);
        #2;
        checks++;
        if (done_cnt - d0 != 1) begin
            errors++; $display("FAIL start_busy_dones got %0d want 1", done_cnt - d0);
        end
    endtask

    task automatic test_async_reset();
        bit to;
        int d0;
        for (int i = 0; i < 8; i++) dist_tab[i] = 16'(i + 3);
        d0 = done_cnt;
        start_run(8, {8{32'h3333_4444}}, 10'd0, 16'd0, 16'd0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks += 3;
        if ({bus.o_busy, bus.o_rd_en, bus.o_dist_ready, bus.o_done, bus.o_found} !== 5'b0) begin
            errors++; $display("FAIL abort_flags got %b want 00000",
                               {bus.o_busy, bus.o_rd_en, bus.o_dist_ready, bus.o_done, bus.o_found});
        end
        if ({bus.o_best_dist, bus.o_second_dist} !== 32'hFFFF_FFFF || bus.o_best_idx !== 10'd0) begin
            errors++; $display("FAIL abort_results got %h %h %0d want ffff ffff 0",
                               bus.o_best_dist, bus.o_second_dist, bus.o_best_idx);
        end
        if (bus.o_dist_value_0 !== 256'd0) begin
            errors++; $display("FAIL abort_query got %h want 0", bus.o_dist_value_0[31:0]);
        end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        #2;
        checks++;
        if (done_cnt != d0) begin
            errors++; $display("FAIL abort_no_done got %0d want 0", done_cnt - d0);
        end
        dist_tab[0] = 16'd5;
        start_run(1, {8{32'h5555_6666}}, 10'd0, 16'd5, 16'hFFFF, 1'b1, 1'b1, 1'b0);
        wait_done(to);
        checks++;
        if (to) begin errors++; $display("FAIL post_reset_timeout got no done want done"); end
    endtask

    initial begin
        bus.i_start      = 1'b0;
        bus.i_query      = 256'd0;
        bus.i_count      = 10'd0;
        bus.i_rd_data    = 256'd0;
        bus.i_dist_ready = 1'b0;
        bus.i_dist_value = 16'd0;
        for (int i = 0; i < 16; i++) dist_tab[i] = 16'hFFFF;
        test_reset();
        test_ratio_reject();
        test_unique_with_reject();
        test_all_rejected();
        test_back_to_back();
        test_zero_count();
        test_start_while_busy();
        test_async_reset();
        repeat (4) @(negedge clk);
        checks++;
        if (sb.size() != 0) begin
            errors++; $display("FAIL scoreboard_left got %0d want 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/match_best_select.md
# match_best_select

Query-side initiator for the descriptor distance unit. For one 256-bit query descriptor from image 1 it streams every candidate descriptor of image 2 from a descriptor RAM into the Hamming-distance unit, one pair per cycle. It collects the in-order distance results and tracks the best and second-best distances. It then reports the best candidate index, qualified by a ratio (uniqueness) test. It sits between the keypoint/descriptor buffers and the match-pair output FIFO of the ORB matcher.

## Interface
- IDX_W, 10: candidate index / address width; up to 2^IDX_W−1 candidates.
- RATIO_NUM, 3: ratio-test numerator.
- RATIO_DEN, 4: ratio-test denominator; unique if best·RATIO_DEN < second·RATIO_NUM.

- i_clk  in  1  clock; all logic on rising edge.
- i_rst_n  in  1  reset, asynchronous, active-low.
- i_start  in  1  start pulse; sampled only in IDLE.
- i_query  in  256  query descriptor; latched on accepted i_start.
- i_count  in  IDX_W  number of candidates N; latched on accepted i_start; 0 legal.
- o_busy  out  1  high from the accepted start until o_done, inclusive.
- o_rd_en  out  1  descriptor RAM read strobe.
- o_rd_addr  out  IDX_W  read address.
- i_rd_data  in  256  RAM data, valid exactly 1 cycle after o_rd_en.
- o_dist_ready  out  1  pair valid to distance unit (its i_value_ready).
- o_dist_value_0  out  256  latched query.
- o_dist_value_1  out  256  candidate, equal to i_rd_data.
- i_dist_ready  in  1  distance result valid (its o_ready).
- i_dist_value  in  16  distance; 16'hFFFF = rejected by threshold.
- o_done  out  1  one-cycle result pulse.
- o_found  out  1  valid unique match.
- o_best_idx  out  IDX_W  index of best candidate.
- o_best_dist  out  16  best distance.
- o_second_dist  out  16  second-best distance.

## Operation
- States: IDLE, ISSUE, DRAIN, DONE.
- IDLE: on i_start, latch i_query and i_count, and clear the counters.
  - Set best = second = 16'hFFFF and best_idx = 0.
  - Go to ISSUE, or to DONE if i_count == 0.
- ISSUE: o_rd_en = 1 every cycle with o_rd_addr = issue counter 0..N−1, then go to DRAIN after address N−1.
  - o_dist_ready = o_rd_en delayed 1 cycle.
  - o_dist_value_1 = i_rd_data; o_dist_value_0 = latched query.
- Result collection runs in ISSUE and DRAIN.
  - Each i_dist_ready takes index = receive counter, which then increments.
  - Results arrive in issue order; the block does not depend on the distance-unit latency.
  - i_dist_ready while no pair is outstanding is ignored.
- Update rule for d = i_dist_value:
  - if d == 16'hFFFF, no change;
  - else if d < best, then second ← best, best ← d, best_idx ← index;
  - else if d < second, then second ← d.
  - Ties keep the lower index as best; an equal distance becomes second.
- DRAIN: go to DONE in the cycle after the receive counter reaches N.
- DONE: for one cycle, assert o_done, drive the result outputs from the registers, then return to IDLE.
- o_found = (best != 16'hFFFF) && (second == 16'hFFFF || best·RATIO_DEN < second·RATIO_NUM).
  - Products are computed at 16+4 bits, unsigned, with no truncation.
- Result outputs hold their value until the next o_done.

## Timing
- Reset values: all outputs 0, except o_best_dist and o_second_dist = 16'hFFFF. State is IDLE, counters 0.
- Cycle 0: i_start accepted. Cycles 1..N: o_rd_en. Cycles 2..N+1: o_dist_ready.
- o_done comes 2 cycles after the Nth i_dist_ready.
- With N = 0: o_done at cycle 1 with o_found = 0.
- Throughput: one pair per cycle; no back-pressure from the distance unit.
- i_start while o_busy is ignored; the query and count are not re-latched.
- Async reset mid-search aborts it: no o_done, and outputs return to reset values immediately.

## Test plan
- N=4, distances 20,10,30,12 → o_done, o_best_idx=1, best=10, second=12, o_found=0 (40 ≥ 36).
- N=3, distances 30,8,FFFF → best_idx=1, best=8, second=30, o_found=1 (32 < 90).
- N=3, all FFFF → o_found=0, best=second=FFFF, best_idx=0.
- N=2, distances 15,15 → best_idx=0, second=15, o_found=0.
- N=0 → o_done at cycle 1, o_found=0; no o_rd_en. Then an i_start pulse during a later N=8 search → ignored, exactly one o_done.
- Reset at cycle 3 of an N=8 search → outputs at reset values, no o_done. A new N=1 run with distance 5 → o_found=1, best_idx=0.
